// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: FSM states, held-instruction record, reset PC.
package fetch_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_DROP = 3'd3,
        ST_HOLD = 3'd4
    } state_e;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        misaligned;
    } inst_t;

    function automatic logic pc_aligned(input logic [31:0] pc);
        return pc[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch stage bundle: imem request/response, execute redirect, decode handshake.
interface fetch_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_misaligned;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        input  redirect_valid, redirect_pc,
        output inst_valid, inst, inst_pc, inst_misaligned,
        input  inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        output redirect_valid, redirect_pc,
        input  inst_valid, inst, inst_pc, inst_misaligned,
        output inst_ready
    );
endinterface

// File: rtl/fetch.sv
// Single-outstanding instruction fetch: REQ -> WAIT -> HOLD, min 3 cycles per instruction.
// Decode backpressure holds the instruction in HOLD; redirects win over every other event.
module fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic    clk,
    input  logic    rst,
    fetch_if.master io
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    inst_t       out_q, out_d;
    logic        vld_q, vld_d;

    logic aligned;
    logic req_fire;

    assign aligned  = pc_aligned(pc_q);
    assign req_fire = io.imem_req_valid & io.imem_req_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            out_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            out_q   <= out_d;
            vld_q   <= vld_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        out_d   = out_q;
        vld_d   = vld_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
                if (io.redirect_valid) pc_d = io.redirect_pc;
            end
            ST_REQ: begin
                if (io.redirect_valid) begin
                    pc_d = io.redirect_pc;
                    // A request accepted this cycle is old-path; its response must be eaten.
                    state_d = req_fire ? ST_DROP : ST_REQ;
                end else if (!aligned) begin
                    out_d.inst       = '0;
                    out_d.pc         = pc_q;
                    out_d.misaligned = 1'b1;
                    vld_d            = 1'b1;
                    state_d          = ST_HOLD;
                end else if (req_fire) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (io.redirect_valid) begin
                    pc_d    = io.redirect_pc;
                    state_d = io.imem_resp_valid ? ST_REQ : ST_DROP;
                end else if (io.imem_resp_valid) begin
                    out_d.inst       = io.imem_resp_data;
                    out_d.pc         = pc_q;
                    out_d.misaligned = 1'b0;
                    vld_d            = 1'b1;
                    pc_d             = pc_q + 32'd4;
                    state_d          = ST_HOLD;
                end
            end
            ST_DROP: begin
                if (io.redirect_valid)  pc_d    = io.redirect_pc;
                if (io.imem_resp_valid) state_d = ST_REQ;
            end
            ST_HOLD: begin
                // The held instruction is younger than the redirecting one, so it dies.
                if (io.redirect_valid) begin
                    vld_d   = 1'b0;
                    pc_d    = io.redirect_pc;
                    state_d = ST_REQ;
                end else if (io.inst_ready) begin
                    vld_d   = 1'b0;
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign io.imem_req_valid  = (state_q == ST_REQ) && aligned;
    assign io.imem_req_addr   = pc_q;
    assign io.inst_valid      = vld_q;
    assign io.inst            = out_q.inst;
    assign io.inst_pc         = out_q.pc;
    assign io.inst_misaligned = out_q.misaligned;

endmodule

// File: tb/tb_fetch.sv
// Directed scoreboard bench for fetch: expected requests/instructions queued by stimulus, checked by a monitor.
module tb_fetch;
    import fetch_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   mem_lat;

    fetch_if bus();

    fetch #(.RESET_PC(32'h0000_0100)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    logic [31:0] exp_req_q[$];
    inst_t       exp_inst_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'h0050_0093;
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_inst(input int bound);
        int n;
        n = 0;
        while (!bus.inst_valid && n < bound) begin
            step();
            n++;
        end
        chk("wait_inst_vld", {31'd0, bus.inst_valid}, 32'd1);
    endtask

    // Memory model: responds mem_lat cycles after each accepted request, even across reset.
    initial begin
        logic        acc, pend;
        logic [31:0] acc_addr, paddr;
        int          acc_lat, lat_cnt;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
        pend    = 1'b0;
        paddr   = '0;
        lat_cnt = 0;
        forever begin
            @(negedge clk);
            acc      = bus.imem_req_valid && bus.imem_req_ready && !rst;
            acc_addr = bus.imem_req_addr;
            acc_lat  = mem_lat;
            @(posedge clk);
            #1;
            bus.imem_resp_valid = 1'b0;
            if (acc) begin
                pend    = 1'b1;
                lat_cnt = acc_lat;
                paddr   = acc_addr;
            end
            if (pend) begin
                lat_cnt--;
                if (lat_cnt == 0) begin
                    bus.imem_resp_valid = 1'b1;
                    bus.imem_resp_data  = mem_word(paddr);
                    pend = 1'b0;
                end
            end
        end
    end

    // Monitor: checks every accepted request and every consumed instruction against the queues.
    initial begin
        inst_t       e;
        logic [31:0] ea;
        forever begin
            @(negedge clk);
            if (!rst && bus.imem_req_valid && bus.imem_req_ready) begin
                if (exp_req_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL req_unexpected: got addr %h expected none at %0t", bus.imem_req_addr, $time);
                end else begin
                    ea = exp_req_q.pop_front();
                    chk("req_addr", bus.imem_req_addr, ea);
                end
            end
            if (!rst && bus.inst_valid && bus.inst_ready && !bus.redirect_valid) begin
                if (exp_inst_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL inst_unexpected: got pc %h expected none at %0t", bus.inst_pc, $time);
                end else begin
                    e = exp_inst_q.pop_front();
                    chk("inst_dat", bus.inst, e.inst);
                    chk("inst_pc", bus.inst_pc, e.pc);
                    chk("inst_mis", {31'd0, bus.inst_misaligned}, {31'd0, e.misaligned});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        checks   = 0;
        failures = 0;
        mem_lat  = 1;
        rst                = 1'b1;
        bus.imem_req_ready = 1'b1;
        bus.inst_ready     = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        chk("rst_inst_vld", {31'd0, bus.inst_valid}, 32'd0);
        chk("rst_req_vld", {31'd0, bus.imem_req_valid}, 32'd0);
        chk("rst_inst", bus.inst, 32'd0);
        chk("rst_inst_pc", bus.inst_pc, 32'd0);
        chk("rst_mis", {31'd0, bus.inst_misaligned}, 32'd0);
        chk("rst_addr", bus.imem_req_addr, 32'h100);

        // 1: first fetch from RESET_PC
        exp_req_q.push_back(32'h100);
        exp_inst_q.push_back('{inst: 32'h0050_0093, pc: 32'h100, misaligned: 1'b0});
        rst = 1'b0;
        wait_inst(10);

        // 2: decode backpressure
        for (int i = 0; i < 5; i++) begin
            chk("bp_inst", bus.inst, 32'h0050_0093);
            chk("bp_inst_pc", bus.inst_pc, 32'h100);
            chk("bp_no_req", {31'd0, bus.imem_req_valid}, 32'd0);
            step();
        end
        mem_lat = 3;
        exp_req_q.push_back(32'h104);
        bus.inst_ready = 1'b1;
        step();
        bus.inst_ready = 1'b0;
        chk("bp_rel_vld", {31'd0, bus.inst_valid}, 32'd0);
        chk("bp_rel_req", {31'd0, bus.imem_req_valid}, 32'd1);
        chk("bp_rel_addr", bus.imem_req_addr, 32'h104);

        // 3: redirect in WAIT, stale response two cycles later
        step();
        mem_lat = 1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h200;
        step();
        bus.redirect_valid = 1'b0;
        chk("drop_no_req", {31'd0, bus.imem_req_valid}, 32'd0);
        exp_req_q.push_back(32'h200);
        step();
        chk("drop_no_req2", {31'd0, bus.imem_req_valid}, 32'd0);
        chk("drop_no_inst", {31'd0, bus.inst_valid}, 32'd0);
        step();
        chk("drop_next_req", {31'd0, bus.imem_req_valid}, 32'd1);
        chk("drop_next_addr", bus.imem_req_addr, 32'h200);

        // 4: redirect together with inst_ready in HOLD kills the instruction
        wait_inst(10);
        chk("hold_pc_200", bus.inst_pc, 32'h200);
        exp_req_q.push_back(32'h300);
        bus.inst_ready     = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h300;
        step();
        bus.redirect_valid = 1'b0;
        bus.inst_ready     = 1'b0;
        chk("kill_vld", {31'd0, bus.inst_valid}, 32'd0);
        chk("kill_addr", bus.imem_req_addr, 32'h300);
        exp_inst_q.push_back('{inst: mem_word(32'h300), pc: 32'h300, misaligned: 1'b0});
        wait_inst(10);
        bus.inst_ready     = 1'b1;
        bus.imem_req_ready = 1'b0;
        step();
        bus.inst_ready = 1'b0;
        chk("seq_addr_304", bus.imem_req_addr, 32'h304);

        // 5: misaligned redirect target
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h302;
        step();
        bus.redirect_valid = 1'b0;
        bus.imem_req_ready = 1'b1;
        chk("mis_no_req", {31'd0, bus.imem_req_valid}, 32'd0);
        step();
        chk("mis_vld", {31'd0, bus.inst_valid}, 32'd1);
        chk("mis_inst", bus.inst, 32'd0);
        chk("mis_pc", bus.inst_pc, 32'h302);
        chk("mis_flag", {31'd0, bus.inst_misaligned}, 32'd1);
        chk("mis_no_req2", {31'd0, bus.imem_req_valid}, 32'd0);
        exp_inst_q.push_back('{inst: 32'd0, pc: 32'h302, misaligned: 1'b1});
        bus.inst_ready = 1'b1;
        step();
        bus.inst_ready = 1'b0;
        chk("mis_no_req3", {31'd0, bus.imem_req_valid}, 32'd0);

        // 6: async reset in the middle of WAIT, late response, then pc wrap
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h400;
        step();
        bus.redirect_valid = 1'b0;
        exp_req_q.push_back(32'h400);
        mem_lat = 3;
        step();
        mem_lat = 1;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_inst_vld", {31'd0, bus.inst_valid}, 32'd0);
        chk("arst_req_vld", {31'd0, bus.imem_req_valid}, 32'd0);
        chk("arst_addr", bus.imem_req_addr, 32'h100);
        step();
        rst = 1'b0;
        bus.imem_req_ready = 1'b0;
        step();
        chk("restart_req", {31'd0, bus.imem_req_valid}, 32'd1);
        chk("restart_addr", bus.imem_req_addr, 32'h100);
        step();
        chk("late_resp_ign_req", {31'd0, bus.imem_req_valid}, 32'd1);
        chk("late_resp_ign_vld", {31'd0, bus.inst_valid}, 32'd0);

        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        step();
        bus.redirect_valid = 1'b0;
        exp_req_q.push_back(32'hFFFF_FFFC);
        exp_inst_q.push_back('{inst: mem_word(32'hFFFF_FFFC), pc: 32'hFFFF_FFFC, misaligned: 1'b0});
        exp_req_q.push_back(32'h0);
        bus.imem_req_ready = 1'b1;
        bus.inst_ready     = 1'b1;
        wait_inst(10);
        step();
        chk("wrap_req", {31'd0, bus.imem_req_valid}, 32'd1);
        chk("wrap_addr", bus.imem_req_addr, 32'h0);
        step();
        bus.imem_req_ready = 1'b0;
        bus.inst_ready     = 1'b0;
        repeat (4) step();

        chk("req_q_empty", exp_req_q.size(), 32'd0);
        chk("inst_q_empty", exp_inst_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
